// File: rtl/mp2_control_pkg.sv
// Shared RV32I control types: datapath mux selects, ALU/CMP ops,
// funct3 encodings and the control FSM state codes.
package mp2_control_pkg;

    typedef enum logic [6:0] {
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111,
        OP_BR    = 7'b1100011,
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_IMM   = 7'b0010011,
        OP_REG   = 7'b0110011
    } opcode_t;

    typedef enum logic [1:0] {
        PCMUX_PC_PLUS4, PCMUX_ALU_OUT, PCMUX_ALU_MOD2
    } pcmux_sel_t;

    typedef enum logic {
        ALUMUX1_RS1_OUT, ALUMUX1_PC_OUT
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        ALUMUX2_I_IMM, ALUMUX2_U_IMM, ALUMUX2_B_IMM,
        ALUMUX2_S_IMM, ALUMUX2_J_IMM, ALUMUX2_RS2_OUT
    } alumux2_sel_t;

    typedef enum logic [3:0] {
        RFMUX_ALU_OUT, RFMUX_BR_EN, RFMUX_U_IMM, RFMUX_LW, RFMUX_PC_PLUS4,
        RFMUX_LB, RFMUX_LBU, RFMUX_LH, RFMUX_LHU
    } regfilemux_sel_t;

    typedef enum logic {
        MARMUX_PC_OUT, MARMUX_ALU_OUT
    } marmux_sel_t;

    typedef enum logic {
        CMPMUX_RS2_OUT, CMPMUX_I_IMM
    } cmpmux_sel_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SLL, ALU_SRA, ALU_SUB,
        ALU_XOR, ALU_SRL, ALU_OR, ALU_AND
    } alu_ops_t;

    typedef enum logic [2:0] {
        BR_BEQ = 3'b000, BR_BNE = 3'b001, BR_BLT = 3'b100,
        BR_BGE = 3'b101, BR_BLTU = 3'b110, BR_BGEU = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        LD_LB = 3'b000, LD_LH = 3'b001, LD_LW = 3'b010,
        LD_LBU = 3'b100, LD_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        ST_SB = 3'b000, ST_SH = 3'b001, ST_SW = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        F3_ADD, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SR, F3_OR, F3_AND
    } arith_funct3_t;

    typedef logic [4:0] ctrl_state_t;

    localparam ctrl_state_t S_FETCH1    = 5'd0;
    localparam ctrl_state_t S_FETCH2    = 5'd1;
    localparam ctrl_state_t S_FETCH3    = 5'd2;
    localparam ctrl_state_t S_DECODE    = 5'd3;
    localparam ctrl_state_t S_IMM       = 5'd4;
    localparam ctrl_state_t S_REG       = 5'd5;
    localparam ctrl_state_t S_LUI       = 5'd6;
    localparam ctrl_state_t S_AUIPC     = 5'd7;
    localparam ctrl_state_t S_BR        = 5'd8;
    localparam ctrl_state_t S_JAL       = 5'd9;
    localparam ctrl_state_t S_JALR      = 5'd10;
    localparam ctrl_state_t S_CALC_ADDR = 5'd11;
    localparam ctrl_state_t S_LD1       = 5'd12;
    localparam ctrl_state_t S_LD2       = 5'd13;
    localparam ctrl_state_t S_ST1       = 5'd14;
    localparam ctrl_state_t S_ST2       = 5'd15;
    localparam ctrl_state_t S_HALT      = 5'd16;

    typedef struct packed {
        pcmux_sel_t      pcmux;
        alumux1_sel_t    alumux1;
        alumux2_sel_t    alumux2;
        regfilemux_sel_t rfmux;
        marmux_sel_t     marmux;
        cmpmux_sel_t     cmpmux;
        alu_ops_t        aluop;
        branch_funct3_t  cmpop;
        logic            load_pc;
        logic            load_ir;
        logic            load_regfile;
        logic            load_mar;
        logic            load_mdr;
        logic            load_data_out;
        logic            mem_read;
        logic            mem_write;
        logic [3:0]      mem_byte_enable;
    } ctrl_t;

    // funct3 already matches alu_ops except for the add/sub and srl/sra pairs
    function automatic alu_ops_t arith_aluop(input logic [2:0] f3,
                                             input logic alt,
                                             input logic is_reg);
        case (f3)
            F3_ADD:  arith_aluop = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            F3_SR:   arith_aluop = alt ? ALU_SRA : ALU_SRL;
            default: arith_aluop = alu_ops_t'(f3);
        endcase
    endfunction

endpackage

// File: rtl/mp2_control.sv
// Multicycle RV32I control FSM: sequences fetch, decode and execute,
// driving every datapath select, load enable and memory request.
module mp2_control
    import mp2_control_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       br_en,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [1:0] mem_addr_lo,
    input  logic       mem_resp,
    output logic [1:0] pcmux_sel,
    output logic       alumux1_sel,
    output logic [2:0] alumux2_sel,
    output logic [3:0] regfilemux_sel,
    output logic       marmux_sel,
    output logic       cmpmux_sel,
    output logic [2:0] aluop,
    output logic [2:0] cmpop,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_data_out,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] mem_byte_enable
);

    ctrl_state_t state_q, state_d;
    ctrl_t       ctrl;
    logic        unused_ok;

    assign unused_ok = ^{rs1, rs2, funct7[6], funct7[4:0]};

    function automatic ctrl_t set_defaults(input logic [2:0] f3);
        ctrl_t c;
        c                 = '0;
        c.aluop           = ALU_ADD;
        c.cmpop           = branch_funct3_t'(f3);
        c.mem_byte_enable = 4'b1111;
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH1;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: if (mem_resp) state_d = S_FETCH3;
            S_FETCH3: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_IMM:   state_d = S_IMM;
                    OP_REG:   state_d = S_REG;
                    OP_LUI:   state_d = S_LUI;
                    OP_AUIPC: state_d = S_AUIPC;
                    OP_BR:    state_d = S_BR;
                    OP_JAL:   state_d = S_JAL;
                    OP_JALR:  state_d = S_JALR;
                    OP_LOAD,
                    OP_STORE: state_d = S_CALC_ADDR;
                    // ST2 only advances the PC, which is exactly a NOP
                    default:  state_d = TRAP_ON_ILLEGAL ? S_HALT : S_ST2;
                endcase
            end
            S_CALC_ADDR: state_d = (opcode == OP_LOAD) ? S_LD1 : S_ST1;
            S_LD1:  if (mem_resp) state_d = S_LD2;
            S_ST1:  if (mem_resp) state_d = S_ST2;
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH1;
        endcase
    end

    always_comb begin
        ctrl = set_defaults(funct3);
        case (state_q)
            S_FETCH1: begin
                ctrl.marmux   = MARMUX_PC_OUT;
                ctrl.load_mar = 1'b1;
            end
            S_FETCH2, S_LD1: begin
                ctrl.mem_read = 1'b1;
                ctrl.load_mdr = 1'b1;
            end
            S_FETCH3: ctrl.load_ir = 1'b1;
            S_IMM, S_REG: begin
                ctrl.alumux1      = ALUMUX1_RS1_OUT;
                ctrl.alumux2      = (state_q == S_REG) ? ALUMUX2_RS2_OUT
                                                       : ALUMUX2_I_IMM;
                ctrl.aluop        = arith_aluop(funct3, funct7[5],
                                                state_q == S_REG);
                ctrl.load_regfile = 1'b1;
                ctrl.load_pc      = 1'b1;
                if (funct3 == F3_SLT || funct3 == F3_SLTU) begin
                    ctrl.rfmux  = RFMUX_BR_EN;
                    ctrl.cmpop  = (funct3 == F3_SLT) ? BR_BLT : BR_BLTU;
                    ctrl.cmpmux = (state_q == S_REG) ? CMPMUX_RS2_OUT
                                                     : CMPMUX_I_IMM;
                end
            end
            S_LUI: begin
                ctrl.rfmux        = RFMUX_U_IMM;
                ctrl.load_regfile = 1'b1;
                ctrl.load_pc      = 1'b1;
            end
            S_AUIPC: begin
                ctrl.alumux1      = ALUMUX1_PC_OUT;
                ctrl.alumux2      = ALUMUX2_U_IMM;
                ctrl.load_regfile = 1'b1;
                ctrl.load_pc      = 1'b1;
            end
            S_BR: begin
                ctrl.alumux1 = ALUMUX1_PC_OUT;
                ctrl.alumux2 = ALUMUX2_B_IMM;
                ctrl.cmpmux  = CMPMUX_RS2_OUT;
                ctrl.pcmux   = br_en ? PCMUX_ALU_OUT : PCMUX_PC_PLUS4;
                ctrl.load_pc = 1'b1;
            end
            S_JAL, S_JALR: begin
                ctrl.rfmux        = RFMUX_PC_PLUS4;
                ctrl.load_regfile = 1'b1;
                ctrl.load_pc      = 1'b1;
                if (state_q == S_JAL) begin
                    ctrl.alumux1 = ALUMUX1_PC_OUT;
                    ctrl.alumux2 = ALUMUX2_J_IMM;
                    ctrl.pcmux   = PCMUX_ALU_OUT;
                end else begin
                    ctrl.alumux1 = ALUMUX1_RS1_OUT;
                    ctrl.alumux2 = ALUMUX2_I_IMM;
                    ctrl.pcmux   = PCMUX_ALU_MOD2;
                end
            end
            S_CALC_ADDR: begin
                ctrl.marmux   = MARMUX_ALU_OUT;
                ctrl.load_mar = 1'b1;
                if (opcode == OP_STORE) begin
                    ctrl.alumux2       = ALUMUX2_S_IMM;
                    ctrl.load_data_out = 1'b1;
                end
            end
            S_LD2: begin
                case (funct3)
                    LD_LB:   ctrl.rfmux = RFMUX_LB;
                    LD_LH:   ctrl.rfmux = RFMUX_LH;
                    LD_LBU:  ctrl.rfmux = RFMUX_LBU;
                    LD_LHU:  ctrl.rfmux = RFMUX_LHU;
                    default: ctrl.rfmux = RFMUX_LW;
                endcase
                ctrl.load_regfile = 1'b1;
                ctrl.load_pc      = 1'b1;
            end
            S_ST1: begin
                ctrl.mem_write = 1'b1;
                case (funct3)
                    ST_SB:   ctrl.mem_byte_enable = 4'b0001 << mem_addr_lo;
                    ST_SH:   ctrl.mem_byte_enable = 4'b0011 << mem_addr_lo;
                    default: ctrl.mem_byte_enable = 4'b1111;
                endcase
            end
            S_ST2: ctrl.load_pc = 1'b1;
            default: ;
        endcase
    end

    assign pcmux_sel       = ctrl.pcmux;
    assign alumux1_sel     = ctrl.alumux1;
    assign alumux2_sel     = ctrl.alumux2;
    assign regfilemux_sel  = ctrl.rfmux;
    assign marmux_sel      = ctrl.marmux;
    assign cmpmux_sel      = ctrl.cmpmux;
    assign aluop           = ctrl.aluop;
    assign cmpop           = ctrl.cmpop;
    assign load_pc         = ctrl.load_pc;
    assign load_ir         = ctrl.load_ir;
    assign load_regfile    = ctrl.load_regfile;
    assign load_mar        = ctrl.load_mar;
    assign load_mdr        = ctrl.load_mdr;
    assign load_data_out   = ctrl.load_data_out;
    assign mem_read        = ctrl.mem_read;
    assign mem_write       = ctrl.mem_write;
    assign mem_byte_enable = ctrl.mem_byte_enable;

endmodule

// File: tb/tb_mp2_control.sv
// Bench for mp2_control: builds the expected per-cycle control trace of
// each instruction from its meaning and compares every cycle.
module tb_mp2_control;
    import mp2_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       br_en, mem_resp;
    logic [4:0] rs1, rs2;
    logic [1:0] mem_addr_lo;
    logic [1:0] pcmux_sel;
    logic       alumux1_sel, marmux_sel, cmpmux_sel;
    logic [2:0] alumux2_sel, aluop, cmpop;
    logic [3:0] regfilemux_sel, mem_byte_enable;
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr;
    logic       load_data_out, mem_read, mem_write;

    always #5 clk = ~clk;

    mp2_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .br_en(br_en), .rs1(rs1), .rs2(rs2),
        .mem_addr_lo(mem_addr_lo), .mem_resp(mem_resp),
        .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel),
        .alumux2_sel(alumux2_sel), .regfilemux_sel(regfilemux_sel),
        .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
        .aluop(aluop), .cmpop(cmpop), .load_pc(load_pc),
        .load_ir(load_ir), .load_regfile(load_regfile),
        .load_mar(load_mar), .load_mdr(load_mdr),
        .load_data_out(load_data_out), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_enable(mem_byte_enable)
    );

    typedef struct packed {
        logic [1:0] pcm;
        logic       a1;
        logic [2:0] a2;
        logic [3:0] rfm;
        logic       mar;
        logic       cmpm;
        logic [2:0] alu;
        logic [2:0] cmp;
        logic       ld_pc, ld_ir, ld_rf, ld_mar, ld_mdr, ld_do;
        logic       rd, wr;
        logic [3:0] be;
    } ob_t;

    // resp: 0/1 drive that value, 2 drive a random (ignored) value
    typedef struct {
        ob_t v;
        ob_t m;
        int  resp;
    } cyc_t;

    cyc_t tr[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string tag, input logic [29:0] got,
                       input logic [29:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic ob_t obs();
        ob_t o;
        o.pcm = pcmux_sel;       o.a1 = alumux1_sel;
        o.a2 = alumux2_sel;      o.rfm = regfilemux_sel;
        o.mar = marmux_sel;      o.cmpm = cmpmux_sel;
        o.alu = aluop;           o.cmp = cmpop;
        o.ld_pc = load_pc;       o.ld_ir = load_ir;
        o.ld_rf = load_regfile;  o.ld_mar = load_mar;
        o.ld_mdr = load_mdr;     o.ld_do = load_data_out;
        o.rd = mem_read;         o.wr = mem_write;
        o.be = mem_byte_enable;
        return o;
    endfunction

    function automatic ob_t dflt(input logic [2:0] f3);
        ob_t o = '0;
        o.be  = 4'b1111;
        o.alu = ALU_ADD;
        o.cmp = f3;
        return o;
    endfunction

    function automatic void push(input ob_t v, input int resp,
                                 input bit skip_alu);
        cyc_t c;
        c.v = v;
        c.m = '1;
        if (skip_alu) c.m.alu = '0;
        c.resp = resp;
        tr.push_back(c);
    endfunction

    // ALU operation an RV32I arithmetic instruction asks for
    function automatic logic [2:0] alu_for(input logic [2:0] f3,
                                           input logic alt, input bit is_reg);
        case (f3)
            3'd0: return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd4: return ALU_XOR;
            3'd5: return alt ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic void build(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic br,
                                  input logic [1:0] lo, input int df,
                                  input int dm);
        ob_t o;
        bit  slt;
        tr.delete();
        o = dflt(f3); o.ld_mar = 1; o.mar = MARMUX_PC_OUT; push(o, 2, 0);
        for (int k = 0; k <= df; k++) begin
            o = dflt(f3); o.rd = 1; o.ld_mdr = 1; push(o, int'(k == df), 0);
        end
        o = dflt(f3); o.ld_ir = 1; push(o, 2, 0);
        push(dflt(f3), 2, 0);
        o = dflt(f3);
        slt = (f3 == 3'd2 || f3 == 3'd3);
        case (op)
            OP_IMM, OP_REG: begin
                o.ld_rf = 1; o.ld_pc = 1; o.pcm = PCMUX_PC_PLUS4;
                o.a1 = ALUMUX1_RS1_OUT;
                o.a2 = (op == OP_REG) ? ALUMUX2_RS2_OUT : ALUMUX2_I_IMM;
                if (slt) begin
                    o.rfm  = RFMUX_BR_EN;
                    o.cmp  = (f3 == 3'd2) ? BR_BLT : BR_BLTU;
                    o.cmpm = (op == OP_REG) ? CMPMUX_RS2_OUT : CMPMUX_I_IMM;
                end else begin
                    o.alu = alu_for(f3, f7[5], op == OP_REG);
                end
                push(o, 2, slt);
            end
            OP_LUI: begin
                o.rfm = RFMUX_U_IMM; o.ld_rf = 1; o.ld_pc = 1;
                push(o, 2, 0);
            end
            OP_AUIPC: begin
                o.a1 = ALUMUX1_PC_OUT; o.a2 = ALUMUX2_U_IMM;
                o.ld_rf = 1; o.ld_pc = 1;
                push(o, 2, 0);
            end
            OP_BR: begin
                o.a1 = ALUMUX1_PC_OUT; o.a2 = ALUMUX2_B_IMM;
                o.cmpm = CMPMUX_RS2_OUT; o.ld_pc = 1;
                o.pcm = br ? PCMUX_ALU_OUT : PCMUX_PC_PLUS4;
                push(o, 2, 0);
            end
            OP_JAL, OP_JALR: begin
                o.rfm = RFMUX_PC_PLUS4; o.ld_rf = 1; o.ld_pc = 1;
                o.a1  = (op == OP_JAL) ? ALUMUX1_PC_OUT : ALUMUX1_RS1_OUT;
                o.a2  = (op == OP_JAL) ? ALUMUX2_J_IMM : ALUMUX2_I_IMM;
                o.pcm = (op == OP_JAL) ? PCMUX_ALU_OUT : PCMUX_ALU_MOD2;
                push(o, 2, 0);
            end
            OP_LOAD: begin
                o.mar = MARMUX_ALU_OUT; o.ld_mar = 1; o.a2 = ALUMUX2_I_IMM;
                push(o, 2, 0);
                for (int k = 0; k <= dm; k++) begin
                    o = dflt(f3); o.rd = 1; o.ld_mdr = 1;
                    push(o, int'(k == dm), 0);
                end
                o = dflt(f3); o.ld_rf = 1; o.ld_pc = 1;
                case (f3)
                    3'd0: o.rfm = RFMUX_LB;
                    3'd1: o.rfm = RFMUX_LH;
                    3'd4: o.rfm = RFMUX_LBU;
                    3'd5: o.rfm = RFMUX_LHU;
                    default: o.rfm = RFMUX_LW;
                endcase
                push(o, 2, 0);
            end
            OP_STORE: begin
                o.mar = MARMUX_ALU_OUT; o.ld_mar = 1;
                o.a2 = ALUMUX2_S_IMM; o.ld_do = 1;
                push(o, 2, 0);
                for (int k = 0; k <= dm; k++) begin
                    o = dflt(f3); o.wr = 1;
                    if (f3 == 3'd0)      o.be = 4'((1 << lo) & 15);
                    else if (f3 == 3'd1) o.be = 4'((3 << lo) & 15);
                    push(o, int'(k == dm), 0);
                end
                o = dflt(f3); o.ld_pc = 1; push(o, 2, 0);
            end
            default: begin
                for (int k = 0; k < 4; k++) push(dflt(f3), 2, 0);
            end
        endcase
    endfunction

    task automatic run(input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic br,
                       input logic [1:0] lo, input int df, input int dm,
                       input int abort_at);
        ob_t g;
        build(op, f3, f7, br, lo, df, dm);
        foreach (tr[i]) begin
            @(negedge clk);
            opcode = op; funct3 = f3; funct7 = f7; br_en = br;
            mem_addr_lo = lo;
            rs1 = 5'($urandom); rs2 = 5'($urandom);
            mem_resp = (tr[i].resp == 2) ? 1'($urandom) : tr[i].resp[0];
            #1;
            g = obs();
            chk($sformatf("op%02h f3=%0d cyc%0d", op, f3, i),
                g & tr[i].m, tr[i].v & tr[i].m);
            if (i == abort_at) begin
                rst = 1'b1; mem_resp = 1'b0;
                @(posedge clk); #1 rst = 1'b0;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_resp = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    logic [6:0] ops [9];
    logic [2:0] f3r, ldf [5];

    initial begin
        ops = '{OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_BR,
                OP_JAL, OP_JALR, OP_LOAD, OP_STORE};
        ldf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; br_en = 0;
        rs1 = '0; rs2 = '0; mem_addr_lo = '0; mem_resp = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        begin
            ob_t e = dflt(3'd0);
            e.ld_mar = 1;
            chk("reset", obs(), e);
        end
        @(posedge clk); #1 rst = 1'b0;

        run(OP_IMM, 3'd0, 7'h00, 0, 2'd0, 0, 0, -1);
        run(OP_IMM, 3'd0, 7'h00, 0, 2'd0, 3, 0, -1);
        run(OP_STORE, ST_SB, 7'h00, 0, 2'b10, 0, 1, -1);
        run(OP_STORE, ST_SH, 7'h00, 0, 2'b10, 1, 0, -1);
        run(OP_BR, BR_BEQ, 7'h00, 1, 2'd0, 0, 0, -1);
        run(OP_BR, BR_BEQ, 7'h00, 0, 2'd0, 0, 0, -1);
        run(OP_REG, 3'd0, 7'h20, 0, 2'd0, 0, 0, -1);
        run(OP_REG, 3'd5, 7'h20, 0, 2'd0, 0, 0, -1);
        run(OP_REG, 3'd3, 7'h00, 1, 2'd0, 0, 0, -1);
        run(OP_LOAD, LD_LW, 7'h00, 0, 2'd0, 0, 3, 5);
        run(OP_JALR, 3'd0, 7'h00, 0, 2'd0, 0, 0, -1);
        run(7'h7F, 3'd0, 7'h00, 0, 2'd0, 0, 0, -1);
        do_reset();

        for (int n = 0; n < 80; n++) begin
            logic [6:0] op, f7;
            op  = ops[$urandom_range(0, 8)];
            f3r = 3'($urandom);
            f7  = 7'h00;
            if (op == OP_LOAD)  f3r = ldf[$urandom_range(0, 4)];
            if (op == OP_STORE) f3r = 3'($urandom_range(0, 2));
            if (op == OP_IMM || f3r == 3'd0 || f3r == 3'd5)
                f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            run(op, f3r, f7, 1'($urandom), 2'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
